// File: rtl/qbus_ram.sv
// Q-bus memory slave: decodes a 22-bit address window and serves DATI/DATO(B)/DATIO
// from an internal word RAM with programmable wait states and open-drain RPLY.
module qbus_ram #(
    parameter logic [21:0] RAM_BASE = 22'o0000000,
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic        pin_clk,
    input  logic        pin_rst,
    inout  wire  [15:0] pin_ad_n,
    input  logic [5:0]  pin_a_n,
    input  logic        pin_bs_n,
    input  logic        pin_sync_n,
    input  logic        pin_wtbt_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_iako_n,
    output logic        pin_rply_n,
    output logic        pin_sel
);

    localparam int unsigned DEPTH = 1 << RAM_AW;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StSkip,
        StWait,
        StRdata,
        StReply
    } state_e;

    state_e            r_state;
    logic              r_rply;
    logic              r_ad_oe;
    logic              r_sel;
    logic              r_write;
    logic [3:0]        r_cnt;
    logic [RAM_AW:0]   r_addr;
    logic [15:0]       r_rdata;
    logic [15:0]       r_mem [DEPTH];

    logic              w_sync;
    logic              w_din;
    logic              w_dout;
    logic              w_wtbt;
    logic              w_bs;
    logic              w_iako;
    logic [15:0]       w_bus;
    logic [21:0]       w_addr;
    logic              w_hit;
    logic              w_strobe;
    logic              w_last;
    logic              w_we;
    logic              w_re;
    logic [RAM_AW-1:0] w_idx;

    assign w_sync   = ~pin_sync_n;
    assign w_din    = ~pin_din_n;
    assign w_dout   = ~pin_dout_n;
    assign w_wtbt   = ~pin_wtbt_n;
    assign w_bs     = ~pin_bs_n;
    assign w_iako   = ~pin_iako_n;
    assign w_bus    = ~pin_ad_n;
    assign w_addr   = {~pin_a_n, w_bus};
    assign w_hit    = ~w_bs & ~w_iako &
                      (w_addr[21:RAM_AW+1] == RAM_BASE[21:RAM_AW+1]);
    assign w_strobe = r_write ? w_dout : w_din;
    assign w_idx    = r_addr[RAM_AW:1];

    // Final wait edge with the strobe still held: commit the write or launch the read.
    assign w_last = (r_state == StWait) && w_sync && w_strobe && (r_cnt == 4'd0);
    assign w_we   = w_last & r_write;
    assign w_re   = w_last & ~r_write;

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            r_state <= StIdle;
            r_rply  <= 1'b0;
            r_ad_oe <= 1'b0;
            r_sel   <= 1'b0;
            r_write <= 1'b0;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
        end else if (!w_sync && r_state != StIdle) begin
            r_state <= StIdle;
            r_rply  <= 1'b0;
            r_ad_oe <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_sync) begin
                        r_addr <= w_addr[RAM_AW:0];
                        if (w_hit) begin
                            r_state <= StSel;
                            r_sel   <= 1'b1;
                        end else begin
                            r_state <= StSkip;
                        end
                    end
                end
                StSkip: r_state <= StSkip;
                StSel: begin
                    if (w_iako) begin
                        r_state <= StSkip;
                        r_sel   <= 1'b0;
                    end else if (w_din) begin
                        r_write <= 1'b0;
                        r_cnt   <= 4'(RAM_WAIT);
                        r_state <= StWait;
                    end else if (w_dout) begin
                        r_write <= 1'b1;
                        r_cnt   <= 4'(RAM_WAIT);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (!w_strobe) begin
                        r_state <= StSel;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_write) begin
                        r_rply  <= 1'b1;
                        r_state <= StReply;
                    end else begin
                        r_state <= StRdata;
                    end
                end
                StRdata: begin
                    if (!w_strobe) begin
                        r_state <= StSel;
                    end else begin
                        r_ad_oe <= 1'b1;
                        r_rply  <= 1'b1;
                        r_state <= StReply;
                    end
                end
                StReply: begin
                    if (!w_strobe) begin
                        r_rply  <= 1'b0;
                        r_ad_oe <= 1'b0;
                        r_state <= StSel;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // RAM is deliberately not reset; byte lanes follow addr[0] when WTBT marks a byte write.
    always_ff @(posedge pin_clk) begin
        if (w_we) begin
            if (!w_wtbt || !r_addr[0]) begin
                r_mem[w_idx][7:0] <= w_bus[7:0];
            end
            if (!w_wtbt || r_addr[0]) begin
                r_mem[w_idx][15:8] <= w_bus[15:8];
            end
        end
        if (w_re) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    assign pin_ad_n   = r_ad_oe ? ~r_rdata : 16'bz;
    assign pin_rply_n = r_rply ? 1'b0 : 1'bz;
    assign pin_sel    = r_sel;

endmodule

// File: tb/tb_qbus_ram.sv
// Bench for qbus_ram: two responders (0 and 3 wait states) share one Q-bus; a timing and
// memory model predicts RPLY, SEL and bus drive every cycle.
module tb_qbus_ram;

    localparam int INF = 1 << 30;
    localparam int WIN = 8192;
    localparam logic [21:0] BASE0 = 22'o0000000;
    localparam logic [21:0] BASE3 = 22'o0040000;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [5:0]  a_n    = '1;
    logic        bs_n   = 1'b1;
    logic        sync_n = 1'b1;
    logic        wtbt_n = 1'b1;
    logic        din_n  = 1'b1;
    logic        dout_n = 1'b1;
    logic        iako_n = 1'b1;
    logic        ad_en  = 1'b0;
    logic [15:0] ad_out = '1;
    logic        sel0;
    logic        sel3;
    tri1  [15:0] ad_n;
    tri1         rply0_n;
    tri1         rply3_n;

    assign ad_n = ad_en ? ad_out : 16'bz;

    always #5 clk = ~clk;

    qbus_ram #(.RAM_BASE(BASE0), .RAM_AW(12), .RAM_WAIT(0)) u_dut0 (
        .pin_clk(clk), .pin_rst(rst), .pin_ad_n(ad_n), .pin_a_n(a_n), .pin_bs_n(bs_n),
        .pin_sync_n(sync_n), .pin_wtbt_n(wtbt_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
        .pin_iako_n(iako_n), .pin_rply_n(rply0_n), .pin_sel(sel0)
    );

    qbus_ram #(.RAM_BASE(BASE3), .RAM_AW(12), .RAM_WAIT(3)) u_dut3 (
        .pin_clk(clk), .pin_rst(rst), .pin_ad_n(ad_n), .pin_a_n(a_n), .pin_bs_n(bs_n),
        .pin_sync_n(sync_n), .pin_wtbt_n(wtbt_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
        .pin_iako_n(iako_n), .pin_rply_n(rply3_n), .pin_sel(sel3)
    );

    // Model state: per-responder SEL and RPLY windows in edge counts, plus memory image.
    int          cyc          = 0;
    int          waits[2]     = '{0, 3};
    int          sel_from[2]  = '{INF, INF};
    int          sel_to[2]    = '{0, 0};
    int          rply_from[2] = '{INF, INF};
    int          rply_to[2]   = '{0, 0};
    int          rd_dut       = -1;
    logic [15:0] rd_val       = '0;
    logic [15:0] mem_m [int];
    int          cur          = -1;
    logic [21:0] cur_addr     = '0;
    int          n_checks     = 0;
    int          n_errors     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d: got %o, expected %o", name, cyc, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int target(input logic [21:0] addr, input bit bs, input bit iako);
        int a;
        a = int'(addr);
        if (bs || iako) return -1;
        if (a >= int'(BASE0) && a < int'(BASE0) + WIN) return 0;
        if (a >= int'(BASE3) && a < int'(BASE3) + WIN) return 1;
        return -1;
    endfunction

    function automatic logic [15:0] exp_ad();
        if (rd_dut >= 0 && cyc >= rply_from[rd_dut] && cyc < rply_to[rd_dut]) return ~rd_val;
        return 16'hFFFF;
    endfunction

    always @(negedge clk) begin
        chk1("rply0", rply0_n, !(cyc >= rply_from[0] && cyc < rply_to[0]));
        chk1("rply3", rply3_n, !(cyc >= rply_from[1] && cyc < rply_to[1]));
        chk1("sel0", sel0, cyc >= sel_from[0] && cyc < sel_to[0]);
        chk1("sel3", sel3, cyc >= sel_from[1] && cyc < sel_to[1]);
        if (!ad_en) chk16("ad_bus", ad_n, exp_ad());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sync(input logic [21:0] addr, input bit bs, input bit iako);
        ad_out   = ~addr[15:0];
        ad_en    = 1'b1;
        a_n      = ~addr[21:16];
        bs_n     = ~bs;
        iako_n   = ~iako;
        sync_n   = 1'b0;
        cur      = target(addr, bs, iako);
        cur_addr = addr;
        if (cur >= 0) begin
            sel_from[cur] = cyc + 1;
            sel_to[cur]   = INF;
        end
        tick();
        ad_en = 1'b0;
    endtask

    task automatic end_sync();
        sync_n = 1'b1;
        iako_n = 1'b1;
        bs_n   = 1'b1;
        a_n    = '1;
        if (cur >= 0) sel_to[cur] = cyc + 1;
        tick();
        tick();
    endtask

    // hold < 0: keep the strobe two edges past the predicted reply (or 100 edges on a miss);
    // hold >= 0: strobe is sampled asserted on exactly that many edges.
    task automatic strobe(input bit rd, input bit bt, input logic [15:0] wdata, input int hold,
                          output logic [15:0] got, output int lat);
        int          t;
        int          rf;
        int          n;
        int          key;
        bit          reply;
        logic [15:0] old;
        got = '0;
        lat = -1;
        key = int'(cur_addr) & ~1;
        if (rd) begin
            din_n = 1'b0;
        end else begin
            dout_n = 1'b0;
            wtbt_n = ~bt;
            ad_out = ~wdata;
            ad_en  = 1'b1;
        end
        t     = cyc + 1;
        rf    = (cur >= 0) ? t + (rd ? 2 : 1) + waits[cur] : INF;
        n     = (hold >= 0) ? hold : ((cur >= 0) ? rf + 2 - t : 100);
        reply = (cur >= 0) && (t + n > rf);
        rd_dut = -1;
        if (reply) begin
            rply_from[cur] = rf;
            rply_to[cur]   = t + n;
            if (rd) begin
                rd_dut = cur;
                rd_val = mem_m.exists(key) ? mem_m[key] : 16'h0;
            end
        end
        for (int i = 0; i < n; i++) begin
            tick();
            if (lat < 0 && (rply0_n == 1'b0 || rply3_n == 1'b0)) begin
                lat = cyc - t;
                got = ~ad_n;
            end
        end
        din_n  = 1'b1;
        dout_n = 1'b1;
        wtbt_n = 1'b1;
        ad_en  = 1'b0;
        if (reply && !rd) begin
            old = mem_m.exists(key) ? mem_m[key] : 16'h0;
            if (!bt) mem_m[key] = wdata;
            else if (cur_addr[0]) mem_m[key] = (old & 16'h00FF) | (wdata & 16'hFF00);
            else mem_m[key] = (old & 16'hFF00) | (wdata & 16'h00FF);
        end
        tick();
    endtask

    initial begin
        logic [15:0] got;
        int          lat;
        int          t;

        repeat (3) tick();
        chk1("reset_rply0", rply0_n, 1'b1);
        chk1("reset_rply3", rply3_n, 1'b1);
        chk1("reset_sel0", sel0, 1'b0);
        chk16("reset_ad", ad_n, 16'hFFFF);
        rst = 1'b0;
        tick();

        chkint("model_hit0", target(22'o0017776, 1'b0, 1'b0), 0);
        chkint("model_gap", target(22'o0020000, 1'b0, 1'b0), -1);
        chkint("model_hit3", target(22'o0057776, 1'b0, 1'b0), 1);

        // Zero wait states: word write then read back.
        start_sync(22'o0000100, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 16'o012345, -1, got, lat);
        chkint("dato_lat", lat, 1);
        end_sync();
        start_sync(22'o0000100, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("dati_lat", lat, 2);
        chk16("dati_data", got, 16'o012345);
        end_sync();

        // Byte writes into each half of the word.
        start_sync(22'o0000101, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 16'o177400, -1, got, lat);
        end_sync();
        chk16("model_byte_hi", mem_m[64], 16'o177745);
        start_sync(22'o0000100, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chk16("datob_hi_data", got, 16'o177745);
        end_sync();
        start_sync(22'o0000100, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 16'o000000, -1, got, lat);
        end_sync();
        start_sync(22'o0000100, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chk16("datob_lo_data", got, 16'o177400);
        end_sync();

        // Three wait states, including a DIN abort before the reply.
        start_sync(22'o0040010, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 16'o123456, -1, got, lat);
        chkint("w3_dato_lat", lat, 4);
        end_sync();
        start_sync(22'o0040010, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("w3_dati_lat", lat, 5);
        chk16("w3_dati_data", got, 16'o123456);
        end_sync();
        start_sync(22'o0040010, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, 2, got, lat);
        chkint("w3_abort_lat", lat, -1);
        end_sync();

        // Silent cases: past each window, bank 7, interrupt acknowledge.
        start_sync(22'o0020000, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("miss_w0_lat", lat, -1);
        end_sync();
        start_sync(22'o0060000, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("miss_w3_lat", lat, -1);
        end_sync();
        start_sync(22'o0000100, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("bs_lat", lat, -1);
        end_sync();
        start_sync(22'o0000100, 1'b0, 1'b1);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("iako_lat", lat, -1);
        end_sync();

        // DATIO: read old value then write new one under a single SYNC.
        start_sync(22'o0000200, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 16'o070707, -1, got, lat);
        end_sync();
        start_sync(22'o0000200, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chk16("datio_rd", got, 16'o070707);
        strobe(1'b0, 1'b0, 16'o111111, -1, got, lat);
        chkint("datio_wr_lat", lat, 1);
        end_sync();
        start_sync(22'o0000200, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chk16("datio_after", got, 16'o111111);
        end_sync();

        // Reset while a read is replying.
        start_sync(22'o0000100, 1'b0, 1'b0);
        din_n        = 1'b0;
        t            = cyc + 1;
        rply_from[0] = t + 2;
        rply_to[0]   = INF;
        rd_dut       = 0;
        rd_val       = mem_m[64];
        repeat (3) tick();
        chk1("rst_pre_rply", rply0_n, 1'b0);
        rply_to[0] = cyc;
        sel_to[0]  = cyc;
        rst = 1'b1;
        #1;
        chk1("rst_rply", rply0_n, 1'b1);
        chk16("rst_ad", ad_n, 16'hFFFF);
        chk1("rst_sel", sel0, 1'b0);
        din_n  = 1'b1;
        sync_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        start_sync(22'o0000200, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0, -1, got, lat);
        chkint("post_rst_lat", lat, 2);
        chk16("post_rst_data", got, 16'o111111);
        end_sync();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
